// File: rtl/shift_pkg.sv
// Shared op codes and helpers for the pipelined logarithmic shifter.
package shift_pkg;

  localparam int SH_SEL_WIDTH = 3;

  typedef enum logic [SH_SEL_WIDTH-1:0] {
    SH_SLL = 3'b001,
    SH_SRL = 3'b010,
    SH_ROR = 3'b011,
    SH_SRA = 3'b100,
    SH_ROL = 3'b101
  } sh_op_e;

  function automatic int sh_latency(input int sa_width, input int reg_every);
    return (sa_width + reg_every - 1) / reg_every;
  endfunction

  function automatic logic sh_op_valid(input logic [SH_SEL_WIDTH-1:0] sel);
    case (sel)
      SH_SLL, SH_SRL, SH_ROR, SH_SRA, SH_ROL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational log level: conditionally shifts/rotates by a fixed distance.
module shift_level
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIST       = 1
) (
  input  logic [SH_SEL_WIDTH-1:0] sel,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    fill_bit,
  output logic [DATA_WIDTH-1:0]   data_out
);

  always_comb begin
    data_out = data_in;
    if (en) begin
      case (sel)
        SH_SLL:  data_out = data_in << DIST;
        SH_SRL:  data_out = data_in >> DIST;
        SH_SRA:  data_out = {{DIST{fill_bit}}, data_in[DATA_WIDTH-1:DIST]};
        SH_ROR:  data_out = {data_in[DIST-1:0], data_in[DATA_WIDTH-1:DIST]};
        SH_ROL:  data_out = {data_in[DATA_WIDTH-DIST-1:0], data_in[DATA_WIDTH-1:DATA_WIDTH-DIST]};
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined logarithmic shifter/rotator with valid/ready flow control and a
// pass-through tag; a register bank follows every REG_EVERY log levels.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH),
  parameter int REG_EVERY  = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SH_SEL_WIDTH-1:0] in_sel,
  input  logic [SA_WIDTH-1:0]     in_amount,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_err
);

  logic adv;

  // Node k is the input of level k; node SA_WIDTH is the output register.
  logic [DATA_WIDTH-1:0]   data_p [SA_WIDTH+1];
  logic [TAG_WIDTH-1:0]    tag_p  [SA_WIDTH+1];
  logic                    err_p  [SA_WIDTH+1];
  logic                    vld_p  [SA_WIDTH+1];
  logic [SH_SEL_WIDTH-1:0] sel_p  [SA_WIDTH];
  logic [SA_WIDTH-1:0]     amt_p  [SA_WIDTH];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Undefined ops enter as zero data and pass every level untouched.
  assign vld_p[0]  = in_valid;
  assign sel_p[0]  = in_sel;
  assign amt_p[0]  = in_amount;
  assign tag_p[0]  = in_tag;
  assign err_p[0]  = ~sh_op_valid(in_sel);
  assign data_p[0] = sh_op_valid(in_sel) ? in_data : '0;

  for (genvar k = 0; k < SA_WIDTH; k++) begin : g_lvl
    logic [DATA_WIDTH-1:0] shifted;

    // The amount is shifted down one bit per level, so bit 0 always enables.
    shift_level #(
      .DATA_WIDTH(DATA_WIDTH),
      .DIST      (1 << k)
    ) u_level (
      .sel     (sel_p[k]),
      .en      (amt_p[k][0]),
      .data_in (data_p[k]),
      .fill_bit(data_p[k][DATA_WIDTH-1]),
      .data_out(shifted)
    );

    if (k == SA_WIDTH - 1) begin : g_out
      logic                  vld_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic [TAG_WIDTH-1:0]  tag_reg;
      logic                  err_reg;

      // ---- output stage ----
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg  <= 1'b0;
          data_reg <= '0;
          tag_reg  <= '0;
          err_reg  <= 1'b0;
        end else if (adv) begin
          vld_reg  <= vld_p[k];
          data_reg <= shifted;
          tag_reg  <= tag_p[k];
          err_reg  <= err_p[k];
        end
      end

      assign vld_p[k+1]  = vld_reg;
      assign data_p[k+1] = data_reg;
      assign tag_p[k+1]  = tag_reg;
      assign err_p[k+1]  = err_reg;
    end else begin : g_mid
      logic [SA_WIDTH-1:0] amt_next;
      assign amt_next = amt_p[k] >> 1;

      if ((k + 1) % REG_EVERY == 0) begin : g_reg
        logic                    vld_reg;
        logic [DATA_WIDTH-1:0]   data_reg;
        logic [TAG_WIDTH-1:0]    tag_reg;
        logic                    err_reg;
        logic [SH_SEL_WIDTH-1:0] sel_reg;
        logic [SA_WIDTH-1:0]     amt_reg;

        // ---- intermediate stage ----
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_reg <= 1'b0;
          end else if (adv) begin
            vld_reg <= vld_p[k];
          end
        end

        always_ff @(posedge clk) begin
          if (adv) begin
            data_reg <= shifted;
            tag_reg  <= tag_p[k];
            err_reg  <= err_p[k];
            sel_reg  <= sel_p[k];
            amt_reg  <= amt_next;
          end
        end

        assign vld_p[k+1]  = vld_reg;
        assign data_p[k+1] = data_reg;
        assign tag_p[k+1]  = tag_reg;
        assign err_p[k+1]  = err_reg;
        assign sel_p[k+1]  = sel_reg;
        assign amt_p[k+1]  = amt_reg;
      end else begin : g_comb
        assign vld_p[k+1]  = vld_p[k];
        assign data_p[k+1] = shifted;
        assign tag_p[k+1]  = tag_p[k];
        assign err_p[k+1]  = err_p[k];
        assign sel_p[k+1]  = sel_p[k];
        assign amt_p[k+1]  = amt_next;
      end
    end
  end

  assign out_valid = vld_p[SA_WIDTH];
  assign out_data  = data_p[SA_WIDTH];
  assign out_tag   = tag_p[SA_WIDTH];
  assign out_err   = err_p[SA_WIDTH];

endmodule
